// File: rtl/alu_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_ctrl
// Purpose  : ALU control decoder (alu_ctr + func -> 4-bit alu_op) combined
//            with an iterative multiply/divide unit owning the HI/LO
//            registers and a pipeline stall handshake.
// Ports    : clk, rst_n (async, active-low)
//            alu_ctr[1:0], func[5:0], valid_in, a, b  - execute-stage inputs
//            alu_op[3:0]   - ALU operation code (combinational)
//            md_rdata      - HI for MFHI, LO for MFLO, else 0 (combinational)
//            stall         - hold pipeline while an MD op waits on busy
//            busy, md_done - mul/div in progress / HI,LO just updated
//            hi, lo        - architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module alu_md_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_ctr,
  input  logic [5:0]       func,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] md_rdata,
  output logic             stall,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opb;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] r_acc_lo;   // multiplier->product low / dividend->quotient
  logic             r_is_div;
  logic             r_dz;       // divide by zero: accumulator already holds result
  logic             r_neg_q;    // negate product or quotient
  logic             r_neg_r;    // negate remainder
  logic             r_busy;
  logic             r_md_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // ---------------- instruction classification ----------------
  logic w_rtype, w_muldiv, w_md_any, w_start, w_mthi_wr, w_mtlo_wr;
  logic w_div_op, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_rtype   = (alu_ctr == 2'b10);
  assign w_muldiv  = w_rtype && (func[5:2] == 4'b0110);
  assign w_md_any  = w_rtype && ((func[5:2] == 4'b0100) || (func[5:2] == 4'b0110));
  assign w_start   = valid_in && !r_busy && w_muldiv;
  assign w_mthi_wr = valid_in && !r_busy && w_rtype && (func == F_MTHI);
  assign w_mtlo_wr = valid_in && !r_busy && w_rtype && (func == F_MTLO);

  // func[0]=0 selects the signed variant, func[1]=1 selects divide.
  assign w_div_op = func[1];
  assign w_a_neg  = !func[0] && a[WIDTH-1];
  assign w_b_neg  = !func[0] && b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;

  // ---------------- ALU operation decode ----------------
  always_comb begin
    alu_op = OP_ADD;
    case (alu_ctr)
      2'b00: alu_op = OP_ADD;
      2'b01: alu_op = OP_SUB;
      2'b11: alu_op = OP_OR;
      default: begin
        casez (func)
          6'b10000?: alu_op = OP_ADD;
          6'b10001?: alu_op = OP_SUB;
          6'b100100: alu_op = OP_AND;
          6'b100101: alu_op = OP_OR;
          6'b100110: alu_op = OP_XOR;
          6'b100111: alu_op = OP_NOR;
          6'b101010: alu_op = OP_SLT;
          6'b101011: alu_op = OP_SLTU;
          default:   alu_op = OP_ADD;
        endcase
      end
    endcase
  end

  // ---------------- iteration datapath ----------------
  // Multiply: add multiplicand to the high half when the multiplier LSB is set,
  // then shift the whole {carry, hi, lo} right by one.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

  // Divide: shift next dividend bit into the remainder and trial-subtract.
  // The remainder stays below the divisor, so bit WIDTH of the difference
  // is a clean borrow flag.
  logic [WIDTH:0] w_div_diff;
  logic           w_div_ge;
  assign w_div_diff = {r_acc_hi, r_acc_lo[WIDTH-1]} - {1'b0, r_opb};
  assign w_div_ge   = !w_div_diff[WIDTH];

  // ---------------- sign correction ----------------
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  assign w_prod_fix = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

  // ---------------- control FSM and HI/LO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_opb     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_is_div  <= 1'b0;
      r_dz      <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_busy    <= 1'b0;
      r_md_done <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_is_div <= w_div_op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (w_div_op && (b == '0)) begin
              // Result is known immediately: LO all ones, HI = dividend.
              r_dz     <= 1'b1;
              r_opb    <= '0;
              r_acc_hi <= a;
              r_acc_lo <= '1;
              r_state  <= ST_FIX;
            end else begin
              r_dz     <= 1'b0;
              r_opb    <= w_div_op ? w_b_abs : w_a_abs;
              r_acc_hi <= '0;
              r_acc_lo <= w_div_op ? w_a_abs : w_b_abs;
              r_state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc_hi <= w_div_ge ? w_div_diff[WIDTH-1:0]
                                 : {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
          end else begin
            r_acc_hi <= w_mul_sum[WIDTH:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          end
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_md_done <= 1'b1;
          if (r_dz) begin
            r_hi <= r_acc_hi;
            r_lo <= r_acc_lo;
          end else if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // MT writes need !busy, so they never collide with the FIX write.
      if (w_mthi_wr) r_hi <= a;
      if (w_mtlo_wr) r_lo <= a;
    end
  end

  assign busy     = r_busy;
  assign md_done  = r_md_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall    = valid_in && r_busy && w_md_any;
  assign md_rdata = (w_rtype && (func == F_MFHI)) ? r_hi :
                    (w_rtype && (func == F_MFLO)) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md_ctrl
// Purpose  : Scoreboard testbench for alu_md_ctrl. Stimulus pushes expected
//            HI/LO/busy-length per mul/div op; a monitor pops on md_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_md_ctrl;

  localparam int WIDTH = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       alu_ctr;
  logic [5:0]       func;
  logic             valid_in;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] md_rdata;
  logic             stall, busy, md_done;
  logic [WIDTH-1:0] hi, lo;

  alu_md_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .alu_ctr(alu_ctr), .func(func),
    .valid_in(valid_in), .a(a), .b(b), .alu_op(alu_op),
    .md_rdata(md_rdata), .stall(stall), .busy(busy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          busy_len = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition.
  function automatic void ref_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output int lat);
    longint      sx, sy, q, r, p;
    logic [63:0] up;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lat = 33;
    rh  = '0;
    rl  = '0;
    if (f == F_MULT) begin
      p = sx * sy; rh = p[63:32]; rl = p[31:0];
    end else if (f == F_MULTU) begin
      up = {32'b0, x} * {32'b0, y}; rh = up[63:32]; rl = up[31:0];
    end else if (y == 32'd0) begin
      rl = 32'hFFFF_FFFF; rh = x; lat = 1;
    end else if (f == F_DIV) begin
      q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0];
    end else begin
      rl = x / y; rh = x % y;
    end
  endfunction

  function automatic logic [3:0] ref_alu_op(input logic [1:0] c, input logic [5:0] f);
    if (c == 2'b00) return 4'd0;
    if (c == 2'b01) return 4'd1;
    if (c == 2'b11) return 4'd3;
    if (f[5:1] == 5'b10000) return 4'd0;
    if (f[5:1] == 5'b10001) return 4'd1;
    if (f == 6'b100100) return 4'd2;
    if (f == 6'b100101) return 4'd3;
    if (f == 6'b100110) return 4'd4;
    if (f == 6'b100111) return 4'd5;
    if (f == 6'b101010) return 4'd6;
    if (f == 6'b101011) return 4'd7;
    return 4'd0;
  endfunction

  // Monitor: compare every HI/LO update against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      busy_len = 0;
    end else begin
      if (md_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_md_done: got md_done=1 required no pulse (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("md_hi", 64'(hi), 64'(e.hi));
          check("md_lo", 64'(lo), 64'(e.lo));
          check("busy_cycles", 64'(busy_len), 64'(e.lat));
          check("busy_low_at_done", 64'(busy), 64'd0);
        end
        busy_len = 0;
      end
      if (busy) busy_len++;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy=%b required 0 within 100 cycles", busy);
    end
  endtask

  // Issue one mul/div with an explicit expected result; returns one cycle later.
  task automatic start_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    wait_idle();
    alu_ctr  = 2'b10;
    func     = f;
    a        = x;
    b        = y;
    valid_in = 1'b1;
    e.hi = eh; e.lo = el; e.lat = lat;
    exp_q.push_back(e);
    model_hi = eh;
    model_lo = el;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic start_ref(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int          lat;
    ref_md(f, x, y, eh, el, lat);
    start_md(f, x, y, eh, el, lat);
  endtask

  task automatic check_mf();
    wait_idle();
    alu_ctr  = 2'b10;
    func     = F_MFHI;
    valid_in = 1'b1;
    #1;
    check("mfhi_rdata", 64'(md_rdata), 64'(model_hi));
    check("mf_no_stall", 64'(stall), 64'd0);
    func = F_MFLO;
    #1;
    check("mflo_rdata", 64'(md_rdata), 64'(model_lo));
    valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_mt(input logic to_hi, input logic [31:0] x);
    wait_idle();
    alu_ctr  = 2'b10;
    func     = to_hi ? F_MTHI : F_MTLO;
    a        = x;
    valid_in = 1'b1;
    #1;
    check("mt_no_stall", 64'(stall), 64'd0);
    @(negedge clk);
    valid_in = 1'b0;
    if (to_hi) begin
      model_hi = x;
      check("mthi_value", 64'(hi), 64'(x));
    end else begin
      model_lo = x;
      check("mtlo_value", 64'(lo), 64'(x));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          n;
    int          pulses;
    logic [5:0]  f;
    logic [31:0] x, y;
    exp_t        e;

    rst_n = 1'b0; alu_ctr = 2'b00; func = '0; valid_in = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_md_done", 64'(md_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode sweep (directed, then random against the table model).
    alu_ctr = 2'b10; func = 6'b100111; #1 check("dec_nor", 64'(alu_op), 64'd5);
    func = 6'b101011; #1 check("dec_sltu", 64'(alu_op), 64'd7);
    func = F_MULT;    #1 check("dec_mult_add", 64'(alu_op), 64'd0);
    alu_ctr = 2'b01;  #1 check("dec_sub", 64'(alu_op), 64'd1);
    alu_ctr = 2'b11;  #1 check("dec_or", 64'(alu_op), 64'd3);
    for (int i = 0; i < 30; i++) begin
      alu_ctr = (i % 3 == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      func    = (i % 2 == 0) ? 6'($urandom_range(32, 47)) : 6'($urandom);
      #1 check("dec_rand", 64'(alu_op), 64'(ref_alu_op(alu_ctr, func)));
    end
    @(negedge clk);

    // Directed mul/div cases.
    start_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    check_mf();
    start_md(F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    check_mf();
    start_md(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    check_mf();
    start_md(F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    check_mf();
    start_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    check_mf();

    // MFLO one cycle behind MULT 6*7: stalls through busy, then reads 42.
    start_md(F_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 33);
    alu_ctr = 2'b10; func = F_MFLO; valid_in = 1'b1;
    #1 check("mflo_stall_start", 64'(stall), 64'd1);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("mflo_stall_cycles", 64'(n), 64'd33);
    check("mflo_release_md_done", 64'(md_done), 64'd1);
    check("mflo_rdata_after", 64'(md_rdata), 64'd42);
    valid_in = 1'b0;
    @(negedge clk);

    // Second MULT held during busy; accepted in the md_done cycle.
    x = $urandom; y = $urandom;
    start_ref(F_MULTU, x, y);
    x = $urandom; y = $urandom;
    alu_ctr = 2'b10; func = F_MULT; a = x; b = y; valid_in = 1'b1;
    #1 check("held_mult_stall", 64'(stall), 64'd1);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("held_mult_md_done", 64'(md_done), 64'd1);
    ref_md(F_MULT, x, y, e.hi, e.lo, e.lat);
    exp_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    @(negedge clk);
    valid_in = 1'b0;
    check("held_mult_accepted", 64'(busy), 64'd1);
    check_mf();

    do_mt(1'b1, 32'h0000_1234);
    check_mf();

    // Randomized mix of mul/div and MT writes.
    for (int i = 0; i < 14; i++) begin
      n = $urandom_range(0, 5);
      if (n < 4) begin
        f = (n == 0) ? F_MULT : (n == 1) ? F_MULTU : (n == 2) ? F_DIV : F_DIVU;
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 5))
          0: y = 32'd0;
          1: y = 32'($urandom_range(1, 15));
          2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
          default: ;
        endcase
        start_ref(f, x, y);
      end else begin
        do_mt(n[0], $urandom);
      end
      check_mf();
    end

    // Asynchronous reset in the middle of a DIVU.
    do_mt(1'b1, 32'hA5A5_0001);
    do_mt(1'b0, 32'h5A5A_0002);
    start_ref(F_DIVU, 32'd123456789, 32'd1000);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_md_done", 64'(md_done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done === 1'b1) pulses++;
    end
    check("aborted_no_md_done", 64'(pulses), 64'd0);

    // Recovery after reset.
    start_ref(F_MULTU, 32'd3, 32'd5);
    check_mf();

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_md_ctrl.md
Name: alu_md_ctrl

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes the 2-bit main-control ALU class plus the R-type func field into a 4-bit ALU operation code. It also adds an iterative multiply/divide unit with HI/LO registers and a pipeline stall handshake. It sits in the execute stage beside the ALU; the datapath consumes alu_op, md_rdata and stall.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (even, >=4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_ctr  in  2  ALU class from main control: 00 add, 01 sub, 11 or, 10 R-type (use func)
func  in  6  instruction func field
valid_in  in  1  instruction in execute stage is valid
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand
alu_op  out  4  ALU operation code (combinational)
md_rdata  out  WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational)
stall  out  1  hold pipeline (combinational)
busy  out  1  mul/div in progress (registered)
md_done  out  1  one-cycle pulse when HI/LO are updated (registered)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous and active-low.
- alu_op encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOR=0101, SLT=0110, SLTU=0111.
- alu_ctr decode: 00 gives ADD; 01 gives SUB; 11 gives OR.
- alu_ctr=10 decode by func:
  - 10000x gives ADD; 10001x gives SUB.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT, 101011 SLTU.
  - All other func values give ADD.
- MD ops (valid only when alu_ctr=10): 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on valid_in & mul/div op, latch |a| and |b| (plain values if unsigned), signs, and op kind. Clear the accumulator, set cnt=0, go to RUN.
  - Exception: DIV/DIVU with b==0 goes straight to FIX.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. cnt increments; after step WIDTH-1, go to FIX.
  - FIX: apply sign correction and write HI/LO. Go to IDLE. md_done=1 in the cycle after the FIX edge.
- Latency: accept at edge E0; busy=1 from after E0 through the FIX edge E(WIDTH+1), i.e. WIDTH+1 cycles. New HI/LO are visible in the same cycle md_done is high. Divide-by-zero: busy for 1 cycle.
- Multiply result: {HI,LO} = full 2*WIDTH-bit product. MULT negates the product when sign(a)^sign(b).
- Divide result: LO = quotient, HI = remainder. DIV quotient sign = sa^sb; remainder sign = sa (truncating division).
- DIV MIN/-1: LO=MIN, HI=0; no exception.
- Divide by zero: LO = all ones, HI = a.
- MTHI/MTLO: when valid_in and not busy, write a into HI/LO at the next edge; single cycle, no busy.
- stall = valid_in & busy & (any MD op). While stalled, nothing is accepted and no write occurs; the upstream stage must hold func/a/b.
- Simultaneous events: a mul/div start and an MT write in the same cycle cannot occur (one instruction per cycle). md_done and a new start can coincide: the new op is accepted in the md_done cycle (busy is already 0).
- md_rdata reads the current HI/LO. After an MFLO stall releases, it shows the newly written value.
- Reset: asynchronous on rst_n low, including mid-operation. State=IDLE, busy=0, md_done=0, hi=0, lo=0, cnt=0, internal operand/accumulator registers cleared. The aborted operation is discarded.
- alu_op is decoded regardless of valid_in. It is ADD for MD funcs.

Test Plan:
- Decode sweep: alu_ctr=10/func=100111 -> alu_op=0101; 101011 -> 0111; 011000 -> 0000; alu_ctr=01 -> 0001; alu_ctr=11 -> 0011.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles, then md_done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=5 b=0 -> busy for 1 cycle; LO=0xFFFFFFFF, HI=5. DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO issued 1 cycle after MULT 6*7 -> stall high until the md_done cycle, then md_rdata=42. A second MULT held during busy is not accepted until md_done; MTHI a=0x1234 while idle -> HI=0x1234 next cycle, no stall.
- rst_n pulsed low at iteration 10 of a DIVU -> busy, md_done, hi, lo are 0 immediately (asynchronously); md_done never pulses for the aborted op.
